// File: rtl/inscache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package inscache_pkg;

    localparam int INS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/inscache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface inscache_if;
    import inscache_pkg::*;

    logic             req_valid;
    logic [INS_W-1:0] req_pc;
    logic             req_ready;
    logic             flush;
    logic             resp_valid;
    logic [INS_W-1:0] resp_ins;
    logic             is_fetch;
    logic [INS_W-1:0] fetch_addr;
    logic             is_back;
    logic [INS_W-1:0] back_ins;

    // Cache view.
    modport slave (
        input  req_valid, req_pc, flush, is_back, back_ins,
        output req_ready, resp_valid, resp_ins, is_fetch, fetch_addr
    );

    // Fetch unit plus memory controller view.
    modport master (
        output req_valid, req_pc, flush, is_back, back_ins,
        input  req_ready, resp_valid, resp_ins, is_fetch, fetch_addr
    );

endinterface

// File: rtl/inscache_array.sv
// Line storage: valid bits cleared asynchronously, tag/data written synchronously, read combinationally.
module inscache_array
    import inscache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [INS_W-1:0]      rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [INS_W-1:0]      wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [INS_W-1:0] data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inscache.sv
// Direct-mapped instruction cache: 1-cycle hits, level miss request to memory, flush-safe fills.
module inscache
    import inscache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    inscache_if.slave  bus
);

    localparam int TAG_W = INS_W - INDEX_BITS - 2;

    state_t           state_q, state_d;
    logic [INS_W-1:0] miss_addr_q, miss_addr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [INS_W-1:0] resp_ins_q, resp_ins_d;
    logic             is_fetch_q, is_fetch_d;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [INS_W-1:0]      rd_data;
    logic                  wr_en;
    logic                  ready;
    logic                  accept, hit, fill;

    assign rd_idx  = bus.req_pc[INDEX_BITS+1:2];
    assign req_tag = bus.req_pc[INS_W-1:INDEX_BITS+2];

    assign accept = (state_q == IDLE) && bus.req_valid && !bus.flush && rdy_in;
    assign hit    = accept && rd_valid && (rd_tag == req_tag);
    // A returning word always fills, even when the fetch unit has moved on.
    assign fill   = (state_q != IDLE) && bus.is_back && rdy_in;

    inscache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (miss_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (miss_addr_q[INS_W-1:INDEX_BITS+2]),
        .wr_data_i  (bus.back_ins)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !hit) state_d = MISS;
            MISS: begin
                if (bus.is_back)    state_d = IDLE;
                else if (bus.flush) state_d = DRAIN;
            end
            DRAIN:   if (bus.is_back) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready        = rst_in && (state_q == IDLE);
        wr_en        = fill;
        resp_valid_d = 1'b0;
        resp_ins_d   = resp_ins_q;
        miss_addr_d  = miss_addr_q;
        is_fetch_d   = (state_d != IDLE);
        if (hit) begin
            resp_valid_d = 1'b1;
            resp_ins_d   = rd_data;
        end else if (accept) begin
            miss_addr_d  = bus.req_pc & ~32'h3;
        end
        if ((state_q == MISS) && bus.is_back && !bus.flush) begin
            resp_valid_d = 1'b1;
            resp_ins_d   = bus.back_ins;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            miss_addr_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_ins_q   <= '0;
            is_fetch_q   <= 1'b0;
        end else if (rdy_in) begin
            miss_addr_q  <= miss_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_ins_q   <= resp_ins_d;
            is_fetch_q   <= is_fetch_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_ins   = resp_ins_q;
    assign bus.is_fetch   = is_fetch_q;
    assign bus.fetch_addr = miss_addr_q;

endmodule
